// File: rtl/sensor_emu_pkg.sv
// rtl/sensor_emu_pkg.sv - shared encodings and widths for the sensor-emulator FIFO sequencer
package sensor_emu_pkg;

    localparam int HALF_W = 32;
    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_F0   = 2'd1,
        SEL_F1   = 2'd2
    } fifo_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } seq_state_e;

    function automatic logic start_legal(input logic [1:0] sel);
        return (sel == SEL_F0) || (sel == SEL_F1);
    endfunction

endpackage

// File: rtl/sensor_emu_fifo_rst_engine.sv
// rtl/sensor_emu_fifo_rst_engine.sv - per-FIFO reset pulse generator with busy wait and status
module sensor_emu_fifo_rst_engine #(
    parameter int RESET_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_i,
    input  logic rst_busy_i,
    output logic rst_o,
    output logic stat_o
);
    import sensor_emu_pkg::*;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_PULSE = 2'd1,
        E_WAIT  = 2'd2
    } eng_state_e;

    eng_state_e state_q;
    logic [7:0] cnt_q;
    logic       rst_q;
    logic       stat_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= E_IDLE;
            cnt_q   <= 8'd0;
            rst_q   <= 1'b0;
            stat_q  <= 1'b0;
        end else begin
            case (state_q)
                E_IDLE: begin
                    if (req_i) begin
                        state_q <= E_PULSE;
                        cnt_q   <= 8'(RESET_CYCLES - 1);
                        rst_q   <= 1'b1;
                        stat_q  <= 1'b1;
                    end
                end
                E_PULSE: begin
                    if (cnt_q == 8'd0) begin
                        rst_q   <= 1'b0;
                        state_q <= E_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                E_WAIT: begin
                    // status stays up through the last cycle the FIFO reports busy
                    if (!rst_busy_i) begin
                        stat_q  <= 1'b0;
                        state_q <= E_IDLE;
                    end
                end
                default: state_q <= E_IDLE;
            endcase
        end
    end

    assign rst_o  = rst_q;
    assign stat_o = stat_q;

endmodule

// File: rtl/sensor_emu_fifo_sequencer.sv
// rtl/sensor_emu_fifo_sequencer.sv - FIFO reset, load and playback arbitration; optional SENSOR_EMU_SEQ_ERRCNT_EN
module sensor_emu_fifo_sequencer
    import sensor_emu_pkg::*;
#(
    parameter int RESET_CYCLES = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_fifo_ctl_f0_reset,
    input  logic                i_fifo_ctl_f1_reset,
    input  logic                i_fifo_ctl_wstrobe,
    input  logic [HALF_W-1:0]   i_upper32,
    input  logic [HALF_W-1:0]   i_load_f0,
    input  logic [HALF_W-1:0]   i_load_f1,
    input  logic                i_load_f0_wstrobe,
    input  logic                i_load_f1_wstrobe,
    input  logic [1:0]          i_start,
    input  logic                i_start_wstrobe,
    input  logic                i_hard_stop_wstrobe,
    output logic                o_f0_rst,
    output logic                o_f1_rst,
    input  logic                i_f0_rst_busy,
    input  logic                i_f1_rst_busy,
    output logic [WORD_W-1:0]   o_f0_wdata,
    output logic [WORD_W-1:0]   o_f1_wdata,
    output logic                o_f0_wen,
    output logic                o_f1_wen,
    input  logic                i_f0_full,
    input  logic                i_f1_full,
    input  logic [WORD_W-1:0]   i_f0_rdata,
    input  logic [WORD_W-1:0]   i_f1_rdata,
    input  logic                i_f0_empty,
    input  logic                i_f1_empty,
    output logic                o_f0_ren,
    output logic                o_f1_ren,
    output logic [WORD_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [1:0]          o_active_fifo,
    output logic                o_fifo_stat_f0_reset,
    output logic                o_fifo_stat_f1_reset
`ifdef SENSOR_EMU_SEQ_ERRCNT_EN
    ,
    output logic [15:0]         o_err_count
`endif
);

    seq_state_e        state_q;
    logic [1:0]        active_q;
    logic [1:0]        pending_q;
    logic [WORD_W-1:0] f0_wdata_q, f1_wdata_q;
    logic              f0_wen_q, f1_wen_q;

    logic busy0, busy1;
    logic rst_req0, rst_req1, acc0, acc1;
    logic act_empty, fire;
    logic start_ok, tgt_empty, tgt_busy, tgt_acc;
    logic idle_take, run_take;
    logic [1:0] pend_eff;
    logic f0_wen_d, f1_wen_d;

    always_comb begin
        rst_req0 = i_fifo_ctl_wstrobe & i_fifo_ctl_f0_reset;
        rst_req1 = i_fifo_ctl_wstrobe & i_fifo_ctl_f1_reset;
        acc0     = rst_req0 & (active_q != SEL_F0) & !busy0;
        acc1     = rst_req1 & (active_q != SEL_F1) & !busy1;

        act_empty = (active_q == SEL_F0) ? i_f0_empty :
                    (active_q == SEL_F1) ? i_f1_empty : 1'b1;

        // hard stop masks the stream in its own cycle so no beat is half-taken
        m_axis_tdata  = (active_q == SEL_F1) ? i_f1_rdata : i_f0_rdata;
        m_axis_tvalid = (state_q == ST_RUN) & !act_empty & !i_hard_stop_wstrobe;
        fire          = m_axis_tvalid & m_axis_tready;
        o_f0_ren      = fire & (active_q == SEL_F0);
        o_f1_ren      = fire & (active_q == SEL_F1);

        start_ok  = i_start_wstrobe & start_legal(i_start) & !i_hard_stop_wstrobe;
        tgt_empty = (i_start == SEL_F1) ? i_f1_empty : i_f0_empty;
        tgt_busy  = (i_start == SEL_F1) ? busy1 : busy0;
        tgt_acc   = (i_start == SEL_F1) ? acc1 : acc0;
        idle_take = (state_q == ST_IDLE) & start_ok & !tgt_busy & !tgt_acc & !tgt_empty;
        run_take  = (state_q == ST_RUN) & start_ok & (i_start != active_q);

        pend_eff = run_take ? i_start : pending_q;
        if ((pend_eff == SEL_F0 && acc0) || (pend_eff == SEL_F1 && acc1))
            pend_eff = SEL_NONE;

        f0_wen_d = i_load_f0_wstrobe & !i_f0_full & !busy0;
        f1_wen_d = i_load_f1_wstrobe & !i_f1_full & !busy1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            active_q  <= SEL_NONE;
            pending_q <= SEL_NONE;
        end else if (i_hard_stop_wstrobe) begin
            state_q   <= ST_IDLE;
            active_q  <= SEL_NONE;
            pending_q <= SEL_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pending_q <= SEL_NONE;
                    if (idle_take) begin
                        state_q  <= ST_RUN;
                        active_q <= i_start;
                    end
                end
                ST_RUN: begin
                    pending_q <= pend_eff;
                    if (act_empty) begin
                        if (pend_eff != SEL_NONE) begin
                            state_q <= ST_SWITCH;
                        end else begin
                            state_q  <= ST_IDLE;
                            active_q <= SEL_NONE;
                        end
                    end
                end
                ST_SWITCH: begin
                    pending_q <= SEL_NONE;
                    if (pend_eff != SEL_NONE) begin
                        state_q  <= ST_RUN;
                        active_q <= pend_eff;
                    end else begin
                        state_q  <= ST_IDLE;
                        active_q <= SEL_NONE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    active_q  <= SEL_NONE;
                    pending_q <= SEL_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            f0_wen_q   <= 1'b0;
            f1_wen_q   <= 1'b0;
            f0_wdata_q <= '0;
            f1_wdata_q <= '0;
        end else begin
            f0_wen_q <= f0_wen_d;
            f1_wen_q <= f1_wen_d;
            if (i_load_f0_wstrobe) f0_wdata_q <= {i_upper32, i_load_f0};
            if (i_load_f1_wstrobe) f1_wdata_q <= {i_upper32, i_load_f1};
        end
    end

    sensor_emu_fifo_rst_engine #(.RESET_CYCLES(RESET_CYCLES)) u_rst_f0 (
        .clk        (clk),
        .resetn     (resetn),
        .req_i      (acc0),
        .rst_busy_i (i_f0_rst_busy),
        .rst_o      (o_f0_rst),
        .stat_o     (busy0)
    );

    sensor_emu_fifo_rst_engine #(.RESET_CYCLES(RESET_CYCLES)) u_rst_f1 (
        .clk        (clk),
        .resetn     (resetn),
        .req_i      (acc1),
        .rst_busy_i (i_f1_rst_busy),
        .rst_o      (o_f1_rst),
        .stat_o     (busy1)
    );

`ifdef SENSOR_EMU_SEQ_ERRCNT_EN
    logic [15:0] err_q;
    logic [2:0]  ev_sum;
    logic [16:0] err_sum;

    always_comb begin
        ev_sum = 3'(i_load_f0_wstrobe & !f0_wen_d) + 3'(i_load_f1_wstrobe & !f1_wen_d)
               + 3'(i_start_wstrobe & !(idle_take | run_take))
               + 3'(rst_req0 & !acc0) + 3'(rst_req1 & !acc1);
        err_sum = {1'b0, err_q} + 17'(ev_sum);
    end

    always_ff @(posedge clk) begin
        if (!resetn)         err_q <= 16'd0;
        else if (err_sum[16]) err_q <= 16'hFFFF;
        else                 err_q <= err_sum[15:0];
    end

    assign o_err_count = err_q;
`endif

    assign o_f0_wdata           = f0_wdata_q;
    assign o_f1_wdata           = f1_wdata_q;
    assign o_f0_wen             = f0_wen_q;
    assign o_f1_wen             = f1_wen_q;
    assign o_active_fifo        = active_q;
    assign o_fifo_stat_f0_reset = busy0;
    assign o_fifo_stat_f1_reset = busy1;

endmodule

// File: doc/sensor_emu_fifo_sequencer.md
Name: sensor_emu_fifo_sequencer

Overview:
Sequencing core behind the sensor-emulator control registers. It drives the two 64-bit playback FIFOs (F0, F1):
- executes FIFO reset requests;
- assembles 64-bit load words and writes them to the FIFOs;
- arbitrates which FIFO streams to the output on start/hard-stop commands, including a one-deep queued hand-off to the other FIFO.

It sits between the AXI register block and the two first-word-fall-through (FWFT) FIFOs. It returns active-FIFO and reset-status to the register block.

Parameters:
RESET_CYCLES, 16, cycles o_fX_rst is held high per reset request (1..255)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
i_fifo_ctl_f0_reset  in  1  request F0 reset (qualified by i_fifo_ctl_wstrobe)
i_fifo_ctl_f1_reset  in  1  request F1 reset (qualified by i_fifo_ctl_wstrobe)
i_fifo_ctl_wstrobe  in  1  FIFO_CTL write strobe
i_upper32  in  32  upper half of load word
i_load_f0 / i_load_f1  in  32  lower half of load word
i_load_f0_wstrobe / i_load_f1_wstrobe  in  1  load strobes
i_start  in  2  1=F0, 2=F1, 0/3 illegal
i_start_wstrobe  in  1  start strobe
i_hard_stop_wstrobe  in  1  hard-stop strobe
o_f0_rst / o_f1_rst  out  1  FIFO reset
i_f0_rst_busy / i_f1_rst_busy  in  1  FIFO reset-busy
o_f0_wdata / o_f1_wdata  out  64  FIFO write data
o_f0_wen / o_f1_wen  out  1  FIFO write enable
i_f0_full / i_f1_full  in  1  FIFO full
i_f0_rdata / i_f1_rdata  in  64  FWFT read data
i_f0_empty / i_f1_empty  in  1  FIFO empty
o_f0_ren / o_f1_ren  out  1  FIFO read enable
m_axis_tdata  out  64  output stream data
m_axis_tvalid  out  1  output stream valid
m_axis_tready  in  1  output stream ready
o_active_fifo  out  2  0=none, 1=F0, 2=F1
o_fifo_stat_f0_reset / o_fifo_stat_f1_reset  out  1  1 while reset in progress

Behaviour:
Reset values:
- All registered outputs are 0 in reset.
- State=IDLE; pending queue empty; reset counters cleared.

FIFO reset (per FIFO, independent engines):
- Request accepted only when that FIFO is neither active nor its engine busy.
- A request for the active FIFO is ignored.
- A request for the pending FIFO is accepted and clears the pending entry.
- Accept -> o_fX_rst=1 for exactly RESET_CYCLES cycles starting the next cycle.
- After that, wait until i_fX_rst_busy=0.
- o_fifo_stat_fX_reset=1 from the cycle after accept through the last busy cycle.

Loads:
- Strobe -> o_fX_wdata={i_upper32,i_load_fX} and o_fX_wen=1 on the next cycle (1-cycle latency).
- The write is dropped if i_fX_full or the reset engine is busy at strobe time.
- Simultaneous F0 and F1 strobes are both honoured.

States:
- IDLE: o_active_fifo=0.
  - Legal start whose target is not resetting and not empty -> RUN, active=target.
  - Any other start is ignored.
- RUN:
  - m_axis_tdata = active rdata (combinational mux).
  - m_axis_tvalid = !empty(active).
  - o_fX_ren = tvalid & tready, active FIFO only.
  - Legal start to the non-active FIFO -> pending=target (overwrites any earlier pending).
  - Start to the active FIFO is ignored.
  - When empty(active)=1 and pending valid -> SWITCH.
  - When empty(active)=1 and no pending -> IDLE.
- SWITCH: one bubble cycle with tvalid=0, then active=pending, pending cleared, -> RUN.

Hard stop:
- Any state -> IDLE next cycle; active=0; pending cleared; no read enable asserted in that cycle.
- Hard stop in the same cycle as start: hard stop wins and the start is discarded.

Optional Feature:
Macro SENSOR_EMU_SEQ_ERRCNT_EN.
- Defined:
  - Adds output o_err_count [15:0], reset 0.
  - Increments once per dropped load, ignored/illegal start, or ignored reset request.
  - Saturates at 16'hFFFF.
  - Multiple events in one cycle add their count.
- Undefined: port absent; drops and ignores are silent.

Decomposition:
- Package sensor_emu_pkg holds:
  - active/start encodings (NONE=0, F0=1, F1=2);
  - state enum (IDLE, RUN, SWITCH);
  - word widths (32, 64).
- One sub-module, sensor_emu_fifo_rst_engine, instantiated twice: rst pulse counter, busy wait, status output.

Test Plan:
- Reset F0 via ctl strobe -> o_f0_rst high exactly 16 cycles; stat high until rst_busy falls.
- Load F0 with upper32=0xAAAA0000, load=0x00001234 -> next cycle o_f0_wen=1, wdata=0xAAAA000000001234.
- Load 4 words to F0 and 3 to F1, start=1, then start=2 while running, tready=1 -> 4 F0 beats, one bubble, 3 F1 beats, then o_active_fifo=0.
- Start=1 with F0 empty, and start=3 -> state stays IDLE, no tvalid (o_err_count=2 with macro).
- RUN with tready toggling 1/0 -> each beat transferred exactly once; hard stop mid-stream -> tvalid=0 next cycle, active=0, remaining F0 data untouched.
- Reset request for active FIFO during RUN -> o_f0_rst stays 0; same cycle start+hard stop from IDLE -> stays IDLE.
